// File: rtl/trace_line_checker.sv
// Checks one trace line per "^...#" on an ASCII stream; decodes the fields and
// reports semantic errors. Optional time/frequency check: define TIME_CHECK_EN.
module trace_line_checker #(
  parameter int unsigned TIME_MAX_DIGITS = 4,
  parameter int unsigned REG_MAX_DIGITS  = 4,
  parameter int unsigned HEX_DIGITS      = 8,
  parameter logic [4*HEX_DIGITS-1:0] PC_LO   = 32'h0000_3000,
  parameter logic [4*HEX_DIGITS-1:0] PC_HI   = 32'h0000_6fff,
  parameter logic [4*HEX_DIGITS-1:0] ADDR_HI = 32'h0000_2fff,
  parameter int unsigned GRF_NUM         = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);

  localparam int VW     = 4 * HEX_DIGITS;
  localparam int TIME_W = $clog2(10 ** TIME_MAX_DIGITS);
  localparam int REG_W  = $clog2(10 ** REG_MAX_DIGITS);
  localparam int MAXD   = (HEX_DIGITS > TIME_MAX_DIGITS) ?
                          ((HEX_DIGITS > REG_MAX_DIGITS) ? HEX_DIGITS : REG_MAX_DIGITS) :
                          ((TIME_MAX_DIGITS > REG_MAX_DIGITS) ? TIME_MAX_DIGITS : REG_MAX_DIGITS);
  localparam int CNT_W  = $clog2(MAXD + 2);

  localparam logic [CNT_W-1:0] C_TMAX = CNT_W'(TIME_MAX_DIGITS);
  localparam logic [CNT_W-1:0] C_RMAX = CNT_W'(REG_MAX_DIGITS);
  localparam logic [CNT_W-1:0] C_HEX  = CNT_W'(HEX_DIGITS);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON_SP, S_REG, S_ADDR,
    S_ARROW_LT, S_ARROW_EQ, S_DATA, S_DONE_REG, S_DONE_MEM, S_ERR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TIME_W-1:0]   r_time, w_time_nxt;
  logic [VW-1:0]       r_pc, w_pc_nxt;
  logic [REG_W-1:0]    r_reg, w_reg_nxt;
  logic [VW-1:0]       r_addr, w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_sp, w_sp_nxt;
  logic                r_mem, w_mem_nxt;
  logic                w_start;

  logic       w_is_dec, w_is_lhex, w_is_hex;
  logic [3:0] w_nib;

  assign w_is_dec  = (char >= "0") && (char <= "9");
  assign w_is_lhex = (char >= "a") && (char <= "f");
  assign w_is_hex  = w_is_dec || w_is_lhex;
  assign w_nib     = w_is_lhex ? (char[3:0] + 4'd9) : char[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_time  <= '0;
      r_pc    <= '0;
      r_reg   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_sp    <= 1'b0;
      r_mem   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_pc    <= w_pc_nxt;
      r_reg   <= w_reg_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sp    <= w_sp_nxt;
      r_mem   <= w_mem_nxt;
    end
  end

  // Digit counters stop at max+1 so an overlong field can never look legal again.
  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_pc_nxt    = r_pc;
    w_reg_nxt   = r_reg;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_sp_nxt    = r_sp;
    w_mem_nxt   = r_mem;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (char == "^") w_start = 1'b1;
      end
      S_TIME: begin
        if (w_is_dec) begin
          if (r_cnt <= C_TMAX) w_cnt_nxt = r_cnt + C_ONE;
          if (r_cnt < C_TMAX) w_time_nxt = r_time * TIME_W'(10) + TIME_W'(w_nib);
        end else if (char == "@" && r_cnt != '0 && r_cnt <= C_TMAX) begin
          w_state_nxt = S_PC;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_PC: begin
        if (w_is_hex) begin
          if (r_cnt <= C_HEX) w_cnt_nxt = r_cnt + C_ONE;
          if (r_cnt < C_HEX) w_pc_nxt = {r_pc[VW-5:0], w_nib};
        end else if (char == ":" && r_cnt == C_HEX) begin
          w_state_nxt = S_COLON_SP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_COLON_SP: begin
        if (char == "$") begin
          w_state_nxt = S_REG;
          w_mem_nxt   = 1'b0;
        end else if (char == "*") begin
          w_state_nxt = S_ADDR;
          w_mem_nxt   = 1'b1;
        end else if (char != " ") begin
          w_state_nxt = S_ERR;
        end
      end
      S_REG: begin
        if (w_is_dec) begin
          if (r_sp) begin
            w_state_nxt = S_ERR;
          end else begin
            if (r_cnt <= C_RMAX) w_cnt_nxt = r_cnt + C_ONE;
            if (r_cnt < C_RMAX) w_reg_nxt = r_reg * REG_W'(10) + REG_W'(w_nib);
          end
        end else if (char == " ") begin
          w_sp_nxt = 1'b1;
        end else if (char == "<" && r_cnt != '0 && r_cnt <= C_RMAX) begin
          w_state_nxt = S_ARROW_LT;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_ADDR: begin
        if (w_is_hex) begin
          if (r_sp) begin
            w_state_nxt = S_ERR;
          end else begin
            if (r_cnt <= C_HEX) w_cnt_nxt = r_cnt + C_ONE;
            if (r_cnt < C_HEX) w_addr_nxt = {r_addr[VW-5:0], w_nib};
          end
        end else if (char == " ") begin
          w_sp_nxt = 1'b1;
        end else if (char == "<" && r_cnt == C_HEX) begin
          w_state_nxt = S_ARROW_LT;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_ARROW_LT: begin
        if (char == "=") begin
          w_state_nxt = S_ARROW_EQ;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_ARROW_EQ: begin
        if (w_is_hex) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = C_ONE;
        end else if (char != " ") begin
          w_state_nxt = S_ERR;
        end
      end
      S_DATA: begin
        if (w_is_hex) begin
          if (r_cnt <= C_HEX) w_cnt_nxt = r_cnt + C_ONE;
        end else if (char == "#" && r_cnt == C_HEX) begin
          w_state_nxt = r_mem ? S_DONE_MEM : S_DONE_REG;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_DONE_REG, S_DONE_MEM: begin
        if (char == "^") w_start = 1'b1;
        else w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (char == "#") w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = S_TIME;
      w_time_nxt  = '0;
      w_pc_nxt    = '0;
      w_reg_nxt   = '0;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_sp_nxt    = 1'b0;
      w_mem_nxt   = 1'b0;
    end
  end

  logic w_pc_err, w_addr_err, w_grf_err, w_time_err;

  assign w_pc_err   = (r_pc < PC_LO) || (r_pc > PC_HI) || (r_pc[1:0] != 2'b00);
  assign w_addr_err = (r_addr > ADDR_HI) || (r_addr[1:0] != 2'b00);
  assign w_grf_err  = (32'(r_reg) >= GRF_NUM);

`ifdef TIME_CHECK_EN
  logic [15:0] w_half;
  logic [15:0] w_rem;
  assign w_half     = {1'b0, freq[15:1]};
  assign w_rem      = (w_half == 16'd0) ? 16'd0 : 16'(32'(r_time) % 32'(w_half));
  assign w_time_err = (w_half == 16'd0) || (w_rem != 16'd0);
`else
  logic w_unused_time;
  assign w_unused_time = ^{freq, r_time};
  assign w_time_err    = 1'b0;
`endif

  always_comb begin
    format_type = 2'd0;
    error_code  = 4'd0;
    case (r_state)
      S_DONE_REG: begin
        format_type = 2'd1;
        error_code  = {w_grf_err, 1'b0, w_pc_err, w_time_err};
      end
      S_DONE_MEM: begin
        format_type = 2'd2;
        error_code  = {1'b0, w_addr_err, w_pc_err, w_time_err};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trace_line_checker.sv
// Bench for trace_line_checker: directed lines plus random lines judged by a
// string-level reference parser; compares {format_type,error_code} every cycle.
module tb_trace_line_checker;

  localparam int          TMAX    = 4;
  localparam int          RMAX    = 4;
  localparam int          HEXD    = 8;
  localparam longint      PC_LO   = 'h3000;
  localparam longint      PC_HI   = 'h6fff;
  localparam longint      ADDR_HI = 'h2fff;
  localparam longint      GRF_NUM = 32;
`ifdef TIME_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  ch;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  trace_line_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, want finish");
    $fatal(1, "watchdog expired");
  end

  // driver: one character per cycle, sampled 1ns after the edge that takes it
  task automatic send(input string s, input bit pulse, input logic [5:0] res);
    for (int k = 0; k < s.len(); k++) begin
      @(negedge clk);
      ch = s.getc(k);
      @(posedge clk);
      #1;
      obs_q.push_back({format_type, error_code});
      exp_q.push_back((pulse && k == s.len() - 1) ? res : 6'd0);
    end
  endtask

  // reference model helpers
  function automatic bit is_dec(input int c);
    return (c >= 48) && (c <= 57);
  endfunction

  function automatic bit is_hex(input int c);
    return is_dec(c) || ((c >= 97) && (c <= 102));
  endfunction

  function automatic longint hexv(input int c);
    return (c >= 97) ? longint'(c - 87) : longint'(c - 48);
  endfunction

  // Parses a whole "^...#" line as text and returns whether it is well formed
  // and the {format_type, error_code} it must report.
  function automatic void model_line(input string s, input int fq, output bit ok,
                                     output logic [5:0] res);
    int n, i, dig;
    longint tv, pcv, fv, h;
    bit mem;
    logic [3:0] ec;
    ok = 1'b0; res = 6'd0; n = s.len(); mem = 1'b0; ec = 4'd0;
    if (n < 2 || s.getc(0) != 8'h5e) return;
    i = 1; dig = 0; tv = 0;
    while (i < n && is_dec(int'(s.getc(i)))) begin
      tv = tv * 10 + hexv(int'(s.getc(i))); dig++; i++;
    end
    if (i >= n || s.getc(i) != 8'h40 || dig < 1 || dig > TMAX) return;
    i++; dig = 0; pcv = 0;
    while (i < n && is_hex(int'(s.getc(i)))) begin
      pcv = pcv * 16 + hexv(int'(s.getc(i))); dig++; i++;
    end
    if (i >= n || s.getc(i) != 8'h3a || dig != HEXD) return;
    i++;
    while (i < n && s.getc(i) == 8'h20) i++;
    if (i >= n) return;
    if (s.getc(i) == 8'h24) mem = 1'b0;
    else if (s.getc(i) == 8'h2a) mem = 1'b1;
    else return;
    i++; dig = 0; fv = 0;
    while (i < n && (mem ? is_hex(int'(s.getc(i))) : is_dec(int'(s.getc(i))))) begin
      fv = fv * (mem ? 16 : 10) + hexv(int'(s.getc(i))); dig++; i++;
    end
    while (i < n && s.getc(i) == 8'h20) i++;
    if (i + 1 >= n || s.getc(i) != 8'h3c || s.getc(i + 1) != 8'h3d) return;
    if (mem ? (dig != HEXD) : (dig < 1 || dig > RMAX)) return;
    i += 2;
    while (i < n && s.getc(i) == 8'h20) i++;
    dig = 0;
    while (i < n && is_hex(int'(s.getc(i)))) begin dig++; i++; end
    if (i != n - 1 || s.getc(i) != 8'h23 || dig != HEXD) return;
    ec[1] = (pcv < PC_LO) || (pcv > PC_HI) || (pcv % 4 != 0);
    if (mem) ec[2] = (fv > ADDR_HI) || (fv % 4 != 0);
    else     ec[3] = (fv >= GRF_NUM);
    if (TCHK) begin
      h = longint'(fq) / 2;
      if (h == 0) ec[0] = 1'b1;
      else        ec[0] = (tv % h != 0);
    end
    ok  = 1'b1;
    res = {(mem ? 2'd2 : 2'd1), ec};
  endfunction

  function automatic string hexfield(input logic [31:0] v);
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return $sformatf("%07h", v[27:0]);
    if (r == 1) return $sformatf("0%08h", v);
    return $sformatf("%08h", v);
  endfunction

  function automatic string spaces(input int n);
    string s;
    s = "";
    for (int j = 0; j < n; j++) s = {s, " "};
    return s;
  endfunction

  function automatic string gen_line();
    string s, cs;
    logic [31:0] v;
    int k, p;
    cs = "A ^<x:@";
    s = "^";
    k = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
    for (int j = 0; j < k; j++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
    case ($urandom_range(0, 3))
      0:       v = 32'(PC_LO) + 4 * $urandom_range(0, 'hfff);
      1:       v = $urandom_range(0, 'h8000);
      2:       v = $urandom;
      default: v = 32'(PC_LO) + 4 * $urandom_range(0, 'hfff) + 2;
    endcase
    s = {s, "@", hexfield(v), ":", spaces($urandom_range(0, 2))};
    if ($urandom_range(0, 1) == 0) begin
      k = $urandom_range(0, 3);
      s = {s, "$", spaces(k == 3 ? 0 : 0)};
      if ($urandom_range(0, 4) == 0) s = {s, "000"};
      s = {s, $sformatf("%0d", $urandom_range(0, 40))};
    end else begin
      case ($urandom_range(0, 2))
        0:       v = 4 * $urandom_range(0, 'hbff);
        1:       v = $urandom_range(0, 'h4000);
        default: v = $urandom;
      endcase
      s = {s, "*", hexfield(v)};
    end
    s = {s, spaces($urandom_range(0, 2)), "<=", spaces($urandom_range(0, 2))};
    s = {s, hexfield($urandom), "#"};
    if ($urandom_range(0, 7) == 0) begin
      p = $urandom_range(1, s.len() - 2);
      s.putc(p, cs.getc($urandom_range(0, cs.len() - 1)));
    end
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ch = (j % 2 == 0) ? 8'h5e : 8'h23;
      @(posedge clk);
      #1;
      n_checks++;
      if ({format_type, error_code} !== 6'd0)
        $display("FAIL reset_outputs cycle %0d: got ft=%0d ec=%b, want ft=0 ec=0000",
                 j, format_type, error_code);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_reg_line();
    logic [5:0] e, o;
    freq = 16'd4;
    send("^10@00003010: $ 5 <= 0000abcd#", 1'b0, 6'd0);
    send("#", 1'b0, 6'd0);
    send("^10@00003010: $5 <=  0000abcd#", 1'b1, {2'd1, 4'b0000});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reg_line cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_mem_line();
    logic [5:0] e, o;
    freq = 16'd8;
    send("^12@00003000: *00000ff8 <= 12345678#", 1'b1, {2'd2, 4'b0000});
    freq = 16'd4;
    send("^7@00002ffe: *00003000 <= 00000000#", 1'b1, {2'd2, 1'b0, 1'b1, 1'b1, TCHK});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL mem_line cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_grf_and_recovery();
    logic [5:0] e, o;
    freq = 16'd2;
    send("^1@00003004: $32<=00000001#", 1'b1, {2'd1, 4'b1000});
    send("^12345@00003004: $1<=00000001#", 1'b0, 6'd0);
    send("^1@00003004: $31<=00000001#", 1'b1, {2'd1, 4'b0000});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL grf_recovery cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    logic [5:0] e, o;
    freq = 16'd2;
    send("^9999@00003000: $0<=00000000#", 1'b1, {2'd1, 4'b0000});
    send("^1@00006ffc: $0031 <= ffffffff#", 1'b1, {2'd1, 4'b0000});
    send("^1@00006fff: $1<=00000000#", 1'b1, {2'd1, 4'b0010});
    send("^1@00007000: *00002ffc<=00000000#", 1'b1, {2'd2, 4'b0010});
    send("^1@00002ffc: *00002fff<=00000000#", 1'b1, {2'd2, 4'b0110});
    send("^1@00003000: $00031<=00000000#", 1'b0, 6'd0);
    send("^1@0000300A: $1<=00000000#", 1'b0, 6'd0);
    send("^1<@00003000: $1<=00000000#", 1'b0, 6'd0);
    send("^1@Q^2@00003000: $1<=00000000#", 1'b0, 6'd0);
    send("^1@00003000: $1<=0000000#", 1'b0, 6'd0);
    send("#", 1'b0, 6'd0);
    send("^1@00003000: $1<=000000000#", 1'b0, 6'd0);
    send("#", 1'b0, 6'd0);
    send("^1@00003000: $1<=00000000#", 1'b1, {2'd1, 4'b0000});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL boundary cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e, o;
    freq = 16'd2;
    send("^10@00003010: $5 <= 0000abcd#", 1'b1, {2'd1, 4'b0000});
    send("^12@00003000: *00000ff8 <= 12345678#", 1'b1, {2'd2, 4'b0000});
    send("^3@00003008: $40<=00000000#", 1'b1, {2'd1, 4'b1000});
    send("  ", 1'b0, 6'd0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL back_to_back cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_line_reset();
    logic [5:0] e, o;
    freq = 16'd2;
    send("^1@0000", 1'b0, 6'd0);
    @(negedge clk);
    reset = 1'b1; ch = 8'h23;
    @(posedge clk);
    #1;
    obs_q.push_back({format_type, error_code}); exp_q.push_back(6'd0);
    reset = 1'b0;
    send("^10@00003010: $5 <=  0000abcd#", 1'b1, {2'd1, 4'b0000});
    send("^12@00003000: *00000ff8 <= 12345678", 1'b0, 6'd0);
    @(negedge clk);
    reset = 1'b1; ch = 8'h23;
    @(posedge clk);
    #1;
    obs_q.push_back({format_type, error_code}); exp_q.push_back(6'd0);
    reset = 1'b0;
    send(" ^12@00003000: *00000ff8 <= 12345678#", 1'b1, {2'd2, 4'b0000});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL mid_line_reset cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [5:0] e, o, res;
    string s, junk, js;
    bit ok;
    js = "ab #z";
    for (int ln = 0; ln < 150; ln++) begin
      freq = 16'($urandom_range(0, 20));
      s = gen_line();
      model_line(s, int'(freq), ok, res);
      send(s, ok, res);
      if (!ok) send("#", 1'b0, 6'd0);
      if ($urandom_range(0, 1) == 0) begin
        junk = "";
        for (int j = 0; j < $urandom_range(1, 3); j++)
          junk = $sformatf("%s%c", junk, js.getc($urandom_range(0, js.len() - 1)));
        send(junk, 1'b0, 6'd0);
      end
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL random cycle %0d: got ft=%0d ec=%b, want ft=%0d ec=%b",
                            k, o[5:4], o[3:0], e[5:4], e[3:0]);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    ch    = 8'h20;
    freq  = 16'd2;
    test_reset();
    test_reg_line();
    test_mem_line();
    test_grf_and_recovery();
    test_boundaries();
    test_back_to_back();
    test_mid_line_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_line_checker.md
# trace_line_checker

Parametrised second-generation checker for the CPU trace character stream: one ASCII character per clock, validating register-write lines `^time@pc: $reg <= data#` and memory-write lines `^time@pc: *addr <= data#`. Beyond format recognition, it decodes the numeric fields and reports semantic errors (PC range/alignment, address range/alignment, register index, time/frequency consistency) on a per-line error code. It sits beside the trace monitor in the single-cycle CPU test harness.

## Interface
- `TIME_MAX_DIGITS`, 4: maximum decimal digits in time (minimum 1).
- `REG_MAX_DIGITS`, 4: maximum decimal digits in register index (minimum 1).
- `HEX_DIGITS`, 8: exact lowercase-hex digit count for pc, addr and data; value width `4*HEX_DIGITS`.
- `PC_LO`, 32'h0000_3000: lowest legal PC.
- `PC_HI`, 32'h0000_6fff: highest legal PC.
- `ADDR_HI`, 32'h0000_2fff: highest legal memory address (lowest is 0).
- `GRF_NUM`, 32: legal register indices are 0 to GRF_NUM-1.
- `clk  input  1  clock`; all state updates on posedge.
- `reset  input  1  synchronous, active-high reset`
- `char  input  8  ASCII character sampled every cycle`
- `freq  input  16  CPU frequency; checked only when TIME_CHECK_EN is defined`
- `format_type  output  2  0 = none/invalid, 1 = register line, 2 = memory line`
- `error_code  output  4  bit0 time, bit1 pc, bit2 addr, bit3 grf; 0 when format_type is 0`

## Operation
- States: IDLE, TIME, PC, COLON_SP, REG, ADDR, ARROW_LT, ARROW_EQ, DATA, DONE_REG, DONE_MEM, ERR.
- IDLE: `^` -> TIME; any other character -> stay.
- TIME: decimal digits accumulate `time = time*10 + d`. `@` with 1..TIME_MAX_DIGITS digits -> PC; otherwise -> ERR.
- PC: `0-9`/`a-f` accumulate `pc = {pc, nibble}`. `:` with exactly HEX_DIGITS digits -> COLON_SP; otherwise -> ERR.
- COLON_SP: spaces are ignored. `$` -> REG, `*` -> ADDR, anything else -> ERR.
- REG: 1..REG_MAX_DIGITS decimal digits, then zero or more spaces, then `<`.
  - A digit after a space -> ERR.
  - A digit count outside the range at `<` -> ERR.
- ADDR: the same rule with exactly HEX_DIGITS hex digits.
- ARROW_LT: the next character must be `=` -> ARROW_EQ; anything else -> ERR.
- ARROW_EQ / DATA:
  - Leading spaces are allowed.
  - Hex digits accumulate data.
  - A space after the first digit -> ERR.
  - `#` with exactly HEX_DIGITS digits -> DONE_REG or DONE_MEM; otherwise -> ERR.
- DONE_*: held exactly one cycle. `^` -> TIME with fields cleared; anything else -> IDLE.
- ERR: wait for `#` -> IDLE. A stray `^` inside ERR does not restart parsing.
- Any character not listed for the current state -> ERR, including uppercase hex, a `^` mid-line, and `<` in TIME or PC.
- Digit counters saturate at max+1, so an overlong field never wraps back into the legal range.
- Semantic checks are evaluated from the accumulated fields while in DONE_*:
  - pc error: `pc < PC_LO || pc > PC_HI || pc[1:0] != 0`.
  - addr error (memory line only): `addr > ADDR_HI || addr[1:0] != 0`.
  - grf error (register line only): `reg >= GRF_NUM`. The register field width must hold REG_MAX_DIGITS decimal digits without overflow.
  - time error: see Configuration.

## Timing
- Reset values:
  - State = IDLE.
  - All counters and fields = 0.
  - `format_type` = 0, `error_code` = 0.
- Reset overrides any character in the same cycle, including mid-line.
- Outputs are decoded combinationally from the registered state and fields; there is no combinational path from `char`.
- The edge that samples a valid `#` enters DONE_*. `format_type`/`error_code` are valid for the following single cycle, then return to 0.
- Back-to-back lines: `#` followed immediately by `^` is legal and produces one pulse per line.
- A line with a format error produces no pulse; its error_code stays 0.

## Configuration
- `TIME_CHECK_EN` defined:
  - Half-frequency is `h = freq >> 1`.
  - error_code bit0 is set when `h == 0` or `time % h != 0`.
  - `freq` is sampled in the DONE_* cycle.
- Not defined: bit0 is tied to 0, `freq` is ignored, and no modulo logic is synthesised.

## Test plan
- Register line:
  - Stimulus `^10@00003010: $ 5 <= 0000abcd#`, freq=4 -> ERR, no pulse (space between `$` and index is illegal).
  - Stimulus `^10@00003010: $5 <=  0000abcd#` -> one cycle of format_type=1, error_code=0.
- Memory line: `^12@00003000: *00000ff8 <= 12345678#`, freq=8 -> format_type=2, error_code=0.
- Memory line `^7@00002ffe: *00003000 <= 00000000#`, freq=4, TIME_CHECK_EN defined -> format_type=2, error_code=4'b0111. Without the macro -> 4'b0110.
- Register line `^1@00003004: $32<=00000001#` -> format_type=1, error_code=4'b1000. Then `^12345@...` (5 time digits) -> no pulse; recovers on the next `#`.
- Reset:
  - Asserting reset mid-line after `^1@0000` -> outputs 0.
  - A following full valid line is accepted normally.
  - Two valid lines back-to-back (`#^`) -> two separate one-cycle pulses.
